// File: rtl/serial_comp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_comp_pkg
// Brief    : Shared types and the result decode for the serial word comparator.
// Revision : 1.0
// ============================================================================
package serial_comp_pkg;

    typedef enum logic {IDLE, RUN} scmp_state_t;

    typedef enum logic [1:0] {RES_LT, RES_EQ, RES_GT} scmp_res_t;

    function automatic logic [2:0] res_to_ges(input scmp_res_t r);
        case (r)
            RES_GT:  return 3'b100;
            RES_LT:  return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_chunk_cmp.sv
`default_nettype none
// ============================================================================
// Module   : serial_chunk_cmp
// Brief    : Combinational unsigned comparator for one LANES-bit chunk.
// Revision : 1.0
// ============================================================================
module serial_chunk_cmp #(
    parameter int LANES = 1
) (
    input  logic [LANES-1:0] a,
    input  logic [LANES-1:0] b,
    output logic             cgt,
    output logic             clt
);

    assign cgt = (a > b);
    assign clt = (a < b);

endmodule
`default_nettype wire

// File: rtl/serial_word_comp.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_comp
// Brief    : Serial magnitude comparator, LANES bits per beat, MSB- or
//            LSB-first. Define SERIAL_CMP_SIGNED_EN for two's-complement.
// Revision : 1.0
// ============================================================================
module serial_word_comp
    import serial_comp_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int WORD_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             start,
    input  logic             lsb_first,
    input  logic [LANES-1:0] serial_a,
    input  logic [LANES-1:0] serial_b,
    output logic             g,
    output logic             e,
    output logic             s,
    output logic             busy,
    output logic             done
);

    localparam int             BEATS    = WORD_W / LANES;
    localparam int             CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam bit             SINGLE   = (BEATS == 1);

    scmp_state_t      state_q, state_d;
    scmp_res_t        res_q,   res_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             order_q, order_d;
    logic             done_q,  done_d;

    logic             w_is_start;
    logic             w_run_beat;
    logic             w_is_last;
    logic             w_order;
    logic [LANES-1:0] w_a_cmp;
    logic [LANES-1:0] w_b_cmp;
    logic             w_cgt;
    logic             w_clt;
    scmp_res_t        w_chunk_res;
    scmp_res_t        w_prev_res;
    scmp_res_t        w_upd_res;

    assign w_is_start = in_valid && start;
    assign w_run_beat = in_valid && !start && (state_q == RUN);
    assign w_is_last  = w_is_start ? SINGLE : (w_run_beat && (cnt_q == LAST_CNT));
    // The start beat uses the order it carries; later beats use the latched one.
    assign w_order    = w_is_start ? lsb_first : order_q;

`ifdef SERIAL_CMP_SIGNED_EN
    logic             w_sign_chunk;
    logic [LANES-1:0] w_sign_mask;

    // Flipping the sign bit maps two's complement onto unsigned ordering.
    assign w_sign_chunk = w_order ? w_is_last : w_is_start;
    assign w_sign_mask  = LANES'(w_sign_chunk) << (LANES - 1);
    assign w_a_cmp      = serial_a ^ w_sign_mask;
    assign w_b_cmp      = serial_b ^ w_sign_mask;
`else
    assign w_a_cmp      = serial_a;
    assign w_b_cmp      = serial_b;
`endif

    serial_chunk_cmp #(
        .LANES (LANES)
    ) u_chunk_cmp (
        .a   (w_a_cmp),
        .b   (w_b_cmp),
        .cgt (w_cgt),
        .clt (w_clt)
    );

    always_comb begin
        w_chunk_res = w_cgt ? RES_GT : (w_clt ? RES_LT : RES_EQ);
        w_prev_res  = w_is_start ? RES_EQ : res_q;
        if (w_order) begin
            w_upd_res = (w_cgt || w_clt) ? w_chunk_res : w_prev_res;
        end else begin
            w_upd_res = (w_prev_res == RES_EQ) ? w_chunk_res : w_prev_res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            res_q   <= RES_EQ;
            cnt_q   <= '0;
            order_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        order_d = order_q;
        done_d  = 1'b0;
        if (w_is_start) begin
            res_d   = w_upd_res;
            order_d = lsb_first;
            if (SINGLE) begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
                cnt_d   = ONE_CNT;
            end
        end else if (w_run_beat) begin
            res_d = w_upd_res;
            if (w_is_last) begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE_CNT;
            end
        end
    end

    assign {g, e, s} = res_to_ges(res_q);
    assign busy      = (state_q == RUN);
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_comp.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_comp
// Brief    : Directed scoreboard bench over three comparator configurations.
// Revision : 1.0
// ============================================================================
module tb_serial_word_comp;

    typedef struct {
        int         cyc;
        int         inst;
        logic [4:0] ex;
        string      name;
    } exp_t;

`ifdef SERIAL_CMP_SIGNED_EN
    localparam logic [4:0] F_MID = 5'b00110;
    localparam logic [4:0] F_FIN = 5'b00101;
`else
    localparam logic [4:0] F_MID = 5'b10010;
    localparam logic [4:0] F_FIN = 5'b10001;
`endif
    localparam logic [4:0] RST_V = 5'b01000;

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t mon_ent;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       v0, st0, l0, a0, b0;
    logic       v1, st1, l1;
    logic [3:0] a1, b1;
    logic       v2, st2, l2;
    logic [1:0] a2, b2;
    logic       g0, e0, s0, bz0, d0;
    logic       g1, e1, s1, bz1, d1;
    logic       g2, e2, s2, bz2, d2;
    logic [4:0] obs [3];

    serial_word_comp #(.LANES(1), .WORD_W(4)) u_l1w4 (
        .clk(clk), .rst(rst), .in_valid(v0), .start(st0), .lsb_first(l0),
        .serial_a(a0), .serial_b(b0),
        .g(g0), .e(e0), .s(s0), .busy(bz0), .done(d0));

    serial_word_comp #(.LANES(4), .WORD_W(8)) u_l4w8 (
        .clk(clk), .rst(rst), .in_valid(v1), .start(st1), .lsb_first(l1),
        .serial_a(a1), .serial_b(b1),
        .g(g1), .e(e1), .s(s1), .busy(bz1), .done(d1));

    serial_word_comp #(.LANES(2), .WORD_W(8)) u_l2w8 (
        .clk(clk), .rst(rst), .in_valid(v2), .start(st2), .lsb_first(l2),
        .serial_a(a2), .serial_b(b2),
        .g(g2), .e(e2), .s(s2), .busy(bz2), .done(d2));

    assign obs[0] = {g0, e0, s0, bz0, d0};
    assign obs[1] = {g1, e1, s1, bz1, d1};
    assign obs[2] = {g2, e2, s2, bz2, d2};

    task automatic chk(input string nm, input int inst, input logic [4:0] got,
                       input logic [4:0] ex);
        total++;
        if (got !== ex) begin
            bad++;
            $display("FAIL %s inst%0d: got gesbd=%b expected %b", nm, inst, got, ex);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_ent = q.pop_front();
            chk(mon_ent.name, mon_ent.inst, obs[mon_ent.inst], mon_ent.ex);
        end
    end

    task automatic idle_all();
        v0 = 0; st0 = 0; l0 = 0; a0 = 0; b0 = 0;
        v1 = 0; st1 = 0; l1 = 0; a1 = 0; b1 = 0;
        v2 = 0; st2 = 0; l2 = 0; a2 = 0; b2 = 0;
    endtask

    // Drive one cycle on one instance and queue what it must show next cycle.
    task automatic step(input int inst, input logic vv, input logic stt,
                        input logic ll, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] ex, input string nm);
        exp_t t;
        @(negedge clk);
        idle_all();
        case (inst)
            0: begin v0 = vv; st0 = stt; l0 = ll; a0 = a[0];   b0 = b[0];   end
            1: begin v1 = vv; st1 = stt; l1 = ll; a1 = a;      b1 = b;      end
            default: begin v2 = vv; st2 = stt; l2 = ll; a2 = a[1:0]; b2 = b[1:0]; end
        endcase
        t.cyc  = cyc + 1;
        t.inst = inst;
        t.ex   = ex;
        t.name = nm;
        q.push_back(t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle_all();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk("reset_state", i, obs[i], RST_V);

        // MSB-first A=1011 B=1010
        step(0, 1, 1, 0, 4'd1, 4'd1, 5'b01010, "msb_b1");
        step(0, 1, 0, 0, 4'd0, 4'd0, 5'b01010, "msb_b2");
        step(0, 1, 0, 0, 4'd1, 4'd1, 5'b01010, "msb_b3");
        step(0, 1, 0, 0, 4'd1, 4'd0, 5'b10001, "msb_done_gt");
        step(0, 0, 0, 0, 4'd0, 4'd0, 5'b10000, "msb_hold");

        // LSB-first A=0110 B=0011; later beats drive lsb_first=0 to test the latch
        step(0, 1, 1, 1, 4'd0, 4'd1, 5'b00110, "lsb_b1");
        step(0, 1, 0, 0, 4'd1, 4'd1, 5'b00110, "lsb_b2");
        step(0, 1, 0, 0, 4'd1, 4'd0, 5'b10010, "lsb_b3");
        step(0, 1, 0, 0, 4'd0, 4'd0, 5'b10001, "lsb_done_gt");

        // 0x5A vs 0x5A then back-to-back 0x12 vs 0x21
        step(1, 1, 1, 0, 4'h5, 4'h5, 5'b01010, "eq_b1");
        step(1, 1, 0, 0, 4'hA, 4'hA, 5'b01001, "eq_done");
        step(1, 1, 1, 0, 4'h1, 4'h2, 5'b00110, "b2b_b1");
        step(1, 1, 0, 0, 4'h2, 4'h1, 5'b00101, "b2b_done_lt");
        step(1, 0, 0, 0, 4'h0, 4'h0, 5'b00100, "b2b_hold");

        // Stall and abort, 2-bit chunks
        step(2, 1, 1, 0, 4'b10, 4'b10, 5'b01010, "stall_b1");
        step(2, 1, 0, 0, 4'b11, 4'b01, 5'b10010, "stall_b2");
        for (int i = 0; i < 3; i++)
            step(2, 0, 0, 0, 4'b00, 4'b11, 5'b10010, "stall_frozen");
        step(2, 1, 1, 0, 4'b01, 4'b01, 5'b01010, "abort_start");
        step(2, 1, 0, 0, 4'b00, 4'b00, 5'b01010, "abort_no_done");
        step(2, 1, 0, 0, 4'b11, 4'b11, 5'b01010, "abort_b3");
        step(2, 1, 0, 0, 4'b00, 4'b10, 5'b00101, "abort_done_lt");

        // Reset in the middle of a word
        step(0, 1, 1, 1, 4'd1, 4'd0, 5'b10010, "rst_b1");
        @(negedge clk);
        v0 = 1; st0 = 0; a0 = 0; b0 = 1;
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk("async_reset", i, obs[i], RST_V);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 0, 4'd1, 4'd0, RST_V, "post_reset_idle");

        // 0x80 vs 0x01 in both orders
        step(1, 1, 1, 0, 4'h8, 4'h0, F_MID, "sgn_msb_b1");
        step(1, 1, 0, 0, 4'h0, 4'h1, F_FIN, "sgn_msb_done");
        step(1, 1, 1, 1, 4'h0, 4'h1, 5'b00110, "sgn_lsb_b1");
        step(1, 1, 0, 0, 4'h8, 4'h0, F_FIN, "sgn_lsb_done");

        step(1, 0, 0, 0, 4'h0, 4'h0, {F_FIN[4:2], 2'b00}, "sgn_hold");
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
